// File: rtl/ca_pixel_writer.sv
// Cell-result to framebuffer writer: maps (x, y, alive) to an Avalon pixel write through a
// small show-ahead FIFO, and clears the whole frame to BG_COLOR after reset or on request.
module ca_pixel_writer #(
  parameter int unsigned      AVN_AW     = 19,
  parameter int unsigned      AVN_DW     = 16,
  parameter int unsigned      H_DISPLAY  = 640,
  parameter int unsigned      V_DISPLAY  = 480,
  parameter int unsigned      XW         = 10,
  parameter int unsigned      YW         = 9,
  parameter int unsigned      FIFO_DEPTH = 4,
  parameter logic [AVN_DW-1:0] FG_COLOR  = 16'hFFFF,
  parameter logic [AVN_DW-1:0] BG_COLOR  = 16'h0000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              clear_req,
  output logic              clear_busy,
  input  logic              cell_valid,
  output logic              cell_ready,
  input  logic [XW-1:0]     cell_x,
  input  logic [YW-1:0]     cell_y,
  input  logic              cell_alive,
  output logic              cell_oob,
  output logic [AVN_AW-1:0] avn_address,
  output logic [AVN_DW-1:0] avn_writedata,
  output logic              avn_write,
  input  logic              avn_waitrequest
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [AVN_AW-1:0] ClrLast = AVN_AW'(H_DISPLAY * V_DISPLAY - 1);

  typedef enum logic [1:0] {StClear, StRun, StDrain} state_e;

  state_e            state_q, state_d;
  logic [AVN_AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              oob_q, oob_d;
  logic [AVN_AW-1:0] mem_addr_q [FIFO_DEPTH];
  logic [AVN_AW-1:0] mem_addr_d [FIFO_DEPTH];
  logic [AVN_DW-1:0] mem_data_q [FIFO_DEPTH];
  logic [AVN_DW-1:0] mem_data_d [FIFO_DEPTH];

  logic              in_range, fifo_empty, fifo_full, ready_int, accept, push, pop;
  logic              clr_done_w, write_int;
  logic [AVN_AW-1:0] cell_addr;

  always_comb begin
    in_range   = (32'(cell_x) < H_DISPLAY) && (32'(cell_y) < V_DISPLAY);
    // Full-width multiply: the largest in-range address still fits AVN_AW bits.
    cell_addr  = AVN_AW'(cell_y) * AVN_AW'(H_DISPLAY) + AVN_AW'(cell_x);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CntW'(FIFO_DEPTH));
    ready_int  = (state_q == StRun) && !fifo_full;
    accept     = cell_valid && ready_int;
    push       = accept && in_range;
    pop        = (state_q != StClear) && !fifo_empty && !avn_waitrequest;
    clr_done_w = (state_q == StClear) && !avn_waitrequest;
    write_int  = (state_q == StClear) || !fifo_empty;
  end

  // Outputs are forced to their idle values while reset is held.
  always_comb begin
    cell_ready    = !sys_rst && ready_int;
    clear_busy    = sys_rst || (state_q != StRun);
    cell_oob      = !sys_rst && oob_q;
    avn_write     = !sys_rst && write_int;
    avn_address   = '0;
    avn_writedata = '0;
    if (!sys_rst) begin
      if (state_q == StClear) begin
        avn_address   = clr_cnt_q;
        avn_writedata = BG_COLOR;
      end else begin
        avn_address   = mem_addr_q[rptr_q];
        avn_writedata = mem_data_q[rptr_q];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StClear: begin
        if (clr_done_w) begin
          if (clr_cnt_q == ClrLast) begin
            clr_cnt_d = '0;
            state_d   = StRun;
          end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
          end
        end
      end
      StRun:   if (clear_req) state_d = StDrain;
      StDrain: if (fifo_empty) state_d = StClear;
      default: state_d = StClear;
    endcase
  end

  always_comb begin
    wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d     = pop ? rptr_q + 1'b1 : rptr_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    oob_d      = accept && !in_range;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    if (push) begin
      mem_addr_d[wptr_q] = cell_addr;
      mem_data_d[wptr_q] = cell_alive ? FG_COLOR : BG_COLOR;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      oob_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      oob_q     <= oob_d;
    end
  end

  // Storage needs no reset: entries are only read once the count says they are valid.
  always_ff @(posedge sys_clk) begin
    mem_addr_q <= mem_addr_d;
    mem_data_q <= mem_data_d;
  end

endmodule

// File: tb/tb_ca_pixel_writer.sv
// Scoreboard bench for ca_pixel_writer; the frame height is shrunk so full clears stay short.
module tb_ca_pixel_writer;

  localparam int unsigned H = 640;
  localparam int unsigned V = 6;
  localparam int unsigned TOTAL = H * V;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        clear_req = 1'b0;
  logic        cell_valid = 1'b0;
  logic        cell_alive = 1'b0;
  logic        avn_waitrequest = 1'b0;
  logic [9:0]  cell_x = '0;
  logic [8:0]  cell_y = '0;
  logic        clear_busy, cell_ready, cell_oob, avn_write;
  logic [18:0] avn_address;
  logic [15:0] avn_writedata;

  ca_pixel_writer #(
    .V_DISPLAY(V)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .clear_req      (clear_req),
    .clear_busy     (clear_busy),
    .cell_valid     (cell_valid),
    .cell_ready     (cell_ready),
    .cell_x         (cell_x),
    .cell_y         (cell_y),
    .cell_alive     (cell_alive),
    .cell_oob       (cell_oob),
    .avn_address    (avn_address),
    .avn_writedata  (avn_writedata),
    .avn_write      (avn_write),
    .avn_waitrequest(avn_waitrequest)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [18:0] addr;
    logic [15:0] data;
    bit          is_clr;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 0;
  bit          oob_set = 0;
  bit          oob_prev = 0;
  bit          prev_stall = 0;
  bit          exp_run = 0;
  logic [18:0] prev_addr;
  logic [15:0] prev_data;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_clear();
    exp_t e;
    for (int i = 0; i < int'(TOTAL); i++) begin
      e.addr = 19'(i);
      e.data = 16'h0000;
      e.is_clr = 1'b1;
      q.push_back(e);
    end
  endfunction

  // Drive one cycle of inputs, then record what the reference model expects from it.
  task automatic tick(input bit v, input int x, input int y, input bit a, input bit creq,
                      input bit w, input bit rst, output bit acc, output bit busy);
    exp_t e;
    @(negedge sys_clk);
    cell_valid = v;
    cell_x = 10'(x);
    cell_y = 9'(y);
    cell_alive = a;
    clear_req = creq;
    avn_waitrequest = w;
    sys_rst = rst;
    #1;
    acc = 1'b0;
    busy = clear_busy;
    if (rst) begin
      q.delete();
      push_clear();
      oob_set = 1'b0;
    end else begin
      if (v && cell_ready) begin
        acc = 1'b1;
        if (x < int'(H) && y < int'(V)) begin
          e.addr = 19'(y * int'(H) + x);
          e.data = a ? 16'hFFFF : 16'h0000;
          e.is_clr = 1'b0;
          q.push_back(e);
        end else begin
          oob_set = 1'b1;
        end
      end
      if (creq && !clear_busy) push_clear();
    end
  endtask

  task automatic wait_done(input bit rw);
    int c = 0;
    bit acc, busy;
    while ((clear_busy || q.size() != 0) && c < 40000) begin
      tick(0, 0, 0, 0, 0, rw && ($urandom_range(0, 3) == 0), 0, acc, busy);
      c++;
    end
    chk(c < 40000, "drain_timeout", c, 40000);
    tick(0, 0, 0, 0, 0, 0, 0, acc, busy);
    tick(0, 0, 0, 0, 0, 0, 0, acc, busy);
  endtask

  // Monitor: pops the scoreboard on every completed write and checks protocol rules.
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      #2;
      if (mon_en) begin
        chk(cell_oob == (oob_prev && !sys_rst), "cell_oob", cell_oob, oob_prev && !sys_rst);
        oob_prev = oob_set;
        oob_set = 1'b0;
        if (sys_rst) begin
          prev_stall = 1'b0;
          exp_run = 1'b0;
        end else begin
          if (exp_run) begin
            chk(!clear_busy && cell_ready, "run_after_clear", {clear_busy, cell_ready}, 1);
            exp_run = 1'b0;
          end
          if (prev_stall) begin
            chk(avn_write && avn_address == prev_addr && avn_writedata == prev_data,
                "avn_hold", {avn_write, avn_address, avn_writedata}, {1'b1, prev_addr, prev_data});
          end
          if (avn_write && !avn_waitrequest) begin
            if (q.size() == 0) begin
              chk(1'b0, "unexpected_write", avn_address, -1);
            end else begin
              e = q.pop_front();
              chk(avn_address == e.addr && avn_writedata == e.data,
                  e.is_clr ? "clear_write" : "cell_write",
                  {avn_address, avn_writedata}, {e.addr, e.data});
              if (e.is_clr) begin
                chk(clear_busy && !cell_ready, "busy_during_clear", {clear_busy, cell_ready}, 2);
                if (e.addr == 19'(TOTAL - 1)) exp_run = 1'b1;
              end
            end
          end
          prev_stall = avn_write && avn_waitrequest;
          prev_addr = avn_address;
          prev_data = avn_writedata;
        end
      end
    end
  end

  initial begin
    bit acc, busy;
    int n;

    // Reset state and the initial full-frame clear
    tick(0, 0, 0, 0, 0, 0, 1, acc, busy);
    mon_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(0, 0, 0, 0, 0, 0, 1, acc, busy);
      chk(!avn_write && avn_address == 0 && avn_writedata == 0, "rst_avn",
          {avn_write, avn_address, avn_writedata}, 0);
      chk(clear_busy && !cell_ready && !cell_oob, "rst_flags",
          {clear_busy, cell_ready, cell_oob}, 4);
    end
    tick(0, 0, 0, 0, 0, 0, 0, acc, busy);
    chk(avn_write && avn_address == 0, "first_clear", {avn_write, avn_address}, {1'b1, 19'd0});
    wait_done(0);
    chk(!clear_busy && cell_ready, "idle_after_clear", {clear_busy, cell_ready}, 1);

    // Single live cell: next-cycle write to 2*640+5
    tick(1, 5, 2, 1, 0, 0, 0, acc, busy);
    chk(acc, "cell_accept", acc, 1);
    tick(0, 0, 0, 0, 0, 0, 0, acc, busy);
    chk(avn_write && avn_address == 1285 && avn_writedata == 16'hFFFF, "cell_latency",
        {avn_write, avn_address, avn_writedata}, {1'b1, 19'd1285, 16'hFFFF});
    tick(0, 0, 0, 0, 0, 0, 0, acc, busy);
    chk(!avn_write, "single_write", avn_write, 0);

    // Backpressure fills the FIFO to exactly its depth
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1, $urandom_range(0, H - 1), $urandom_range(0, V - 1), 1'($urandom), 0, 1, 0, acc, busy);
      n += int'(acc);
    end
    chk(n == 4, "bp_accept_count", n, 4);
    chk(!cell_ready, "bp_ready_low", cell_ready, 0);
    wait_done(0);

    // Out-of-range cells pulse cell_oob and write nothing; the last in-range cell does write
    tick(1, H, 0, 1, 0, 0, 0, acc, busy);
    chk(acc, "oob_x_accept", acc, 1);
    tick(0, 0, 0, 0, 0, 0, 0, acc, busy);
    chk(cell_oob && !avn_write, "oob_x_pulse", {cell_oob, avn_write}, 2);
    tick(0, 0, 0, 0, 0, 0, 0, acc, busy);
    chk(!cell_oob, "oob_x_once", cell_oob, 0);
    tick(1, 0, V, 1, 0, 0, 0, acc, busy);
    chk(acc, "oob_y_accept", acc, 1);
    tick(0, 0, 0, 0, 0, 0, 0, acc, busy);
    chk(cell_oob && !avn_write, "oob_y_pulse", {cell_oob, avn_write}, 2);
    tick(1, H - 1, V - 1, 1, 0, 0, 0, acc, busy);
    tick(0, 0, 0, 0, 0, 0, 0, acc, busy);
    chk(avn_write && avn_address == 19'(TOTAL - 1) && !cell_oob, "corner_cell",
        {avn_write, avn_address}, {1'b1, 19'(TOTAL - 1)});
    wait_done(0);

    // clear_req with three cells buffered: cells drain first, then the clear
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1, $urandom_range(0, H - 1), $urandom_range(0, V - 1), 1, 0, 1, 0, acc, busy);
      n += int'(acc);
    end
    chk(n == 3, "pre_clear_fill", n, 3);
    tick(0, 0, 0, 0, 1, 1, 0, acc, busy);
    n = 0;
    do begin
      tick(1, $urandom_range(0, H - 1), $urandom_range(0, V - 1), 1,
           $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, 0, acc, busy);
      if (busy) chk(!acc, "accept_while_busy", acc, 0);
      n++;
    end while (clear_busy && n < 40000);
    chk(n < 40000, "clear_req_timeout", n, 40000);
    wait_done(0);

    // Randomised traffic with occasional clear requests
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom), $urandom_range(0, 700), $urandom_range(0, 7), 1'($urandom),
           $urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, 0, acc, busy);
    end
    wait_done(1);

    // Reset while stalled with a full FIFO
    for (int i = 0; i < 6; i++) begin
      tick(1, $urandom_range(0, H - 1), $urandom_range(0, V - 1), 1, 0, 1, 0, acc, busy);
    end
    chk(!cell_ready, "full_before_rst", cell_ready, 0);
    tick(0, 0, 0, 0, 0, 1, 1, acc, busy);
    tick(0, 0, 0, 0, 0, 1, 1, acc, busy);
    chk(!avn_write && !cell_ready && clear_busy, "mid_rst",
        {avn_write, cell_ready, clear_busy}, 1);
    tick(0, 0, 0, 0, 0, 1, 0, acc, busy);
    chk(avn_write && avn_address == 0 && avn_writedata == 0, "clear_restart",
        {avn_write, avn_address, avn_writedata}, {1'b1, 19'd0, 16'd0});
    wait_done(1);

    chk(q.size() == 0, "scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
